// File: rtl/sha_digest_hex_tx_pkg.sv
// Shared definitions for the SHA digest hex transmitter: serializer state
// encodings, the nibble-to-ASCII mapping and the frame terminator byte.
package sha_digest_hex_tx_pkg;

    // Serializer states. LOAD is the single gap cycle between frames.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } ser_state_t;

    // Optional end-of-frame byte (line feed).
    localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

    // 0-9 -> '0'-'9' (0x30-0x39), 10-15 -> 'a'-'f' (0x61-0x66).
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] res;
        if (nib < 4'd10) begin
            res = 8'h30 + {4'h0, nib};
        end else begin
            res = 8'h57 + {4'h0, nib};
        end
        return res;
    endfunction

endpackage

// File: rtl/sha_digest_hex_tx_if.sv
// Bus bundle between a SHA core, the hex transmitter and the byte sink.
//
// Handshake rules for the byte stream: a byte transfers on every rising clk
// edge where otvalid and otready are both 1. Once otvalid is raised it stays
// high, and otdata/otlast/otid stay unchanged, until that transfer happens.
// otready may change freely. The digest side has no backpressure: ivalid is a
// one-cycle strobe and iid/isha are only meaningful while it is high.
interface sha_digest_hex_tx_if #(
    parameter int DIGEST_W = 160
);
    logic                ivalid;
    logic [31:0]         iid;
    logic [DIGEST_W-1:0] isha;
    logic                otvalid;
    logic                otready;
    logic [7:0]          otdata;
    logic                otlast;
    logic [31:0]         otid;
    logic                drop;

    // Core and sink side (drives digests, accepts bytes).
    modport master (
        output ivalid, iid, isha, otready,
        input  otvalid, otdata, otlast, otid, drop
    );

    // Transmitter side.
    modport slave (
        input  ivalid, iid, isha, otready,
        output otvalid, otdata, otlast, otid, drop
    );
endinterface

// File: rtl/sha_digest_fifo.sv
// Synchronous FIFO holding {id, digest} entries. A push is accepted while
// full if a pop happens in the same cycle. The head entry is visible on
// rd_data without a read latency.
module sha_digest_fifo #(
    parameter int W     = 192,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rptr_q];

    // Accept/retire decisions and next pointer/occupancy values.
    always_comb begin
        pop     = rd_en && !empty;
        push    = wr_en && (!full || pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/sha_digest_hex_tx.sv
// SHA digest to ASCII hex byte stream. Each digest strobe is queued with its
// message ID; the serializer then emits DIGEST_W/4 lowercase hex characters,
// most-significant nibble first, with otlast on the final byte of the frame.
//
// Build option: define SHA_HEX_NEWLINE_EN to append a 0x0A byte to every
// frame; otlast then moves onto that byte.
//
// The frame being sent keeps its FIFO slot until its last byte is accepted,
// so the FIFO depth counts the frame in flight. That last-byte handshake is
// the pop that frees room for a digest arriving in the same cycle.
module sha_digest_hex_tx
    import sha_digest_hex_tx_pkg::*;
#(
    parameter int DIGEST_W = 160,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    sha_digest_hex_tx_if.slave bus,
    output ser_state_t  dbg_state
);
    localparam int NCHAR = DIGEST_W / 4;
`ifdef SHA_HEX_NEWLINE_EN
    localparam int NBYTES = NCHAR + 1;
`else
    localparam int NBYTES = NCHAR;
`endif
    localparam int CW = $clog2(NCHAR + 1);
    localparam int FW = DIGEST_W + 32;
    localparam int QW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
    localparam logic [CW-1:0] LAST_HEX = CW'(NCHAR - 1);

    // FIFO connections.
    logic                fifo_wr;
    logic                fifo_rd;
    logic [FW-1:0]       fifo_wdata;
    logic [FW-1:0]       fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [QW-1:0]       fifo_count;
    logic [31:0]         head_id;
    logic [DIGEST_W-1:0] head_sha;

    // Serializer state and registered outputs.
    ser_state_t          state_q, state_d;
    logic [DIGEST_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic                otvalid_q, otvalid_d;
    logic [7:0]          otdata_q, otdata_d;
    logic                otlast_q, otlast_d;
    logic [31:0]         otid_q, otid_d;
    logic                drop_q, drop_d;

    logic                frame_done;
    logic                push_ok;
    logic [CW-1:0]       idx_inc;

    assign fifo_wdata = {bus.iid, bus.isha};
    assign head_id    = fifo_rdata[FW-1 -: 32];
    assign head_sha   = fifo_rdata[DIGEST_W-1:0];
    assign fifo_wr    = bus.ivalid;
    assign fifo_rd    = frame_done;

    sha_digest_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Last-byte handshake, the capture decision and the drop pulse source.
    always_comb begin
        frame_done = (state_q == ST_SEND) && otvalid_q && bus.otready && otlast_q;
        push_ok    = bus.ivalid && (!fifo_full || frame_done);
        drop_d     = bus.ivalid && !push_ok;
        idx_inc    = idx_q + 1'b1;
    end

    // Serializer next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        otvalid_d = otvalid_q;
        otdata_d  = otdata_q;
        otlast_d  = otlast_q;
        otid_d    = otid_q;
        case (state_q)
            ST_IDLE: begin
                // A digest captured this cycle is enough to start loading.
                if (!fifo_empty || push_ok) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Present the first character now; the shift register keeps
                // the remaining nibbles with the next one at the top.
                shreg_d   = head_sha << 4;
                otdata_d  = nibble_to_ascii(head_sha[DIGEST_W-1 -: 4]);
                idx_d     = '0;
                otvalid_d = 1'b1;
                otlast_d  = 1'b0;
                otid_d    = head_id;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (bus.otready) begin
                    if (otlast_q) begin
                        otvalid_d = 1'b0;
                        otlast_d  = 1'b0;
                        // Head retires now; anything left behind it, or a
                        // digest captured this cycle, starts the next frame.
                        if ((fifo_count > QW'(1)) || push_ok) begin
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d    = idx_inc;
                        otlast_d = (idx_inc == LAST_IDX);
                        if (idx_q < LAST_HEX) begin
                            otdata_d = nibble_to_ascii(shreg_q[DIGEST_W-1 -: 4]);
                            shreg_d  = shreg_q << 4;
                        end else begin
                            otdata_d = ASCII_NEWLINE;
                        end
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                otvalid_d = 1'b0;
                otlast_d  = 1'b0;
            end
        endcase
    end

    // Serializer and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            otvalid_q <= 1'b0;
            otdata_q  <= 8'h00;
            otlast_q  <= 1'b0;
            otid_q    <= 32'h0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            otvalid_q <= otvalid_d;
            otdata_q  <= otdata_d;
            otlast_q  <= otlast_d;
            otid_q    <= otid_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.otvalid = otvalid_q;
    assign bus.otdata  = otdata_q;
    assign bus.otlast  = otlast_q;
    assign bus.otid    = otid_q;
    assign bus.drop    = drop_q;
    assign dbg_state   = state_q;

endmodule
